// File: rtl/hmac_multiblock_pkg.sv
// rtl/hmac_multiblock_pkg.sv - shared types, pads, SHA-384/512 constants and round helpers
package hmac_multiblock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IPAD,
        ST_MSG,
        ST_WAIT_MSG,
        ST_HMAC,
        ST_DONE
    } state_e;

    localparam logic [1:0] SHA_MODE_384 = 2'h2;
    localparam logic [1:0] SHA_MODE_512 = 2'h3;

    localparam logic [1023:0] IPAD = {128{8'h36}};
    localparam logic [1023:0] OPAD = {128{8'h5c}};

    // Outer-hash padding: the length field counts the 1024-bit opad block plus the inner digest.
    localparam logic [639:0] FINAL_PAD_384 = {8'h80, 616'h0, 16'h0580};
    localparam logic [511:0] FINAL_PAD_512 = {8'h80, 488'h0, 16'h0600};

    localparam logic [511:0] SHA384_IV = {
        64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
        64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4
    };
    localparam logic [511:0] SHA512_IV = {
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };

    // Round constant t lives at bits [(79-t)*64 +: 64].
    localparam logic [80*64-1:0] SHA512_K = {
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    function automatic logic [63:0] big_sigma0(input logic [63:0] x);
        return {x[27:0], x[63:28]} ^ {x[33:0], x[63:34]} ^ {x[38:0], x[63:39]};
    endfunction

    function automatic logic [63:0] big_sigma1(input logic [63:0] x);
        return {x[13:0], x[63:14]} ^ {x[17:0], x[63:18]} ^ {x[40:0], x[63:41]};
    endfunction

    function automatic logic [63:0] small_sigma0(input logic [63:0] x);
        return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ {7'b0, x[63:7]};
    endfunction

    function automatic logic [63:0] small_sigma1(input logic [63:0] x);
        return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ {6'b0, x[63:6]};
    endfunction

    function automatic logic [511:0] add_words(input logic [511:0] x, input logic [511:0] y);
        logic [511:0] r;
        for (int i = 0; i < 8; i++) begin
            r[64*i +: 64] = x[64*i +: 64] + y[64*i +: 64];
        end
        return r;
    endfunction

endpackage

// File: rtl/hmac_lfsr.sv
// rtl/hmac_lfsr.sv - 32-bit Galois LFSR with seed load, used as masking entropy source
module hmac_lfsr #(
    parameter logic [31:0] INIT = 32'h1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        load_i,
    input  logic [31:0] seed_i,
    output logic [31:0] value_o
);

    localparam logic [31:0] POLY = 32'h0040_0007;

    logic [31:0] lfsr_q;

    // An all-zero seed would lock the register, so fall back to the reset seed.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            lfsr_q <= INIT;
        end else if (load_i) begin
            lfsr_q <= (seed_i == 32'h0) ? INIT : seed_i;
        end else begin
            lfsr_q <= {lfsr_q[30:0], 1'b0} ^ (lfsr_q[31] ? POLY : 32'h0);
        end
    end

    assign value_o = lfsr_q;

endmodule

// File: rtl/hmac_multiblock_core_final_block_mux.sv
// rtl/hmac_multiblock_core_final_block_mux.sv - builds the padded outer-hash block from the inner digest
module hmac_final_block_mux
    import hmac_multiblock_pkg::*;
(
    input  logic [511:0]  digest_i,
    input  logic          mode_512_i,
    output logic [1023:0] block_o
);

    assign block_o = mode_512_i ? {digest_i, FINAL_PAD_512}
                                : {digest_i[511:128], FINAL_PAD_384};

endmodule

// File: rtl/sha512_masked_core.sv
// rtl/sha512_masked_core.sv - one-round-per-cycle SHA-384/512 block engine with masked chaining value
module sha512_masked_core
    import hmac_multiblock_pkg::*;
(
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic          zeroize_i,
    input  logic          init_i,
    input  logic          next_i,
    input  logic [1:0]    mode_i,
    input  logic [1023:0] block_i,
    input  logic [191:0]  entropy_i,
    output logic          ready_o,
    output logic [511:0]  digest_o
);

    logic          busy_q;
    logic [6:0]    round_q;
    logic [511:0]  v_q;
    logic [1023:0] w_q;
    logic [511:0]  h_q;
    logic [511:0]  mask_q;

    logic [511:0]  chain;
    logic [511:0]  start_val;
    logic [511:0]  fresh_mask;
    logic [511:0]  v_d;
    logic [63:0]   w_new;
    logic [63:0]   k_word;
    logic [6:0]    k_idx;
    logic [63:0]   t1, t2;

    // The chaining value is only ever stored XOR-ed with a mask refreshed every block.
    assign chain      = h_q ^ mask_q;
    assign fresh_mask = {entropy_i, entropy_i, entropy_i[191:64]};
    assign start_val  = init_i ? ((mode_i == SHA_MODE_512) ? SHA512_IV : SHA384_IV) : chain;

    assign k_idx  = (round_q < 7'd80) ? (7'd79 - round_q) : 7'd0;
    assign k_word = SHA512_K[{k_idx, 6'b0} +: 64];

    always_comb begin
        t1 = v_q[63:0] + big_sigma1(v_q[255:192])
           + ((v_q[255:192] & v_q[191:128]) ^ (~v_q[255:192] & v_q[127:64]))
           + k_word + w_q[1023:960];
        t2 = big_sigma0(v_q[511:448])
           + ((v_q[511:448] & v_q[447:384]) ^ (v_q[511:448] & v_q[383:320]) ^ (v_q[447:384] & v_q[383:320]));
        v_d = {t1 + t2, v_q[511:448], v_q[447:384], v_q[383:320],
               v_q[319:256] + t1, v_q[255:192], v_q[191:128], v_q[127:64]};
        // Word 0 of the window is W[t]; this produces W[t+16].
        w_new = small_sigma1(w_q[127:64]) + w_q[447:384] + small_sigma0(w_q[959:896]) + w_q[1023:960];
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni || zeroize_i) begin
            busy_q  <= 1'b0;
            round_q <= 7'd0;
            v_q     <= '0;
            w_q     <= '0;
            h_q     <= '0;
            mask_q  <= '0;
        end else if (!busy_q) begin
            if (init_i || next_i) begin
                busy_q  <= 1'b1;
                round_q <= 7'd0;
                w_q     <= block_i;
                v_q     <= start_val;
                h_q     <= start_val ^ fresh_mask;
                mask_q  <= fresh_mask;
            end
        end else if (round_q == 7'd80) begin
            busy_q <= 1'b0;
            h_q    <= add_words(chain, v_q) ^ fresh_mask;
            mask_q <= fresh_mask;
        end else begin
            round_q <= round_q + 7'd1;
            v_q     <= v_d;
            w_q     <= {w_q[959:0], w_new};
        end
    end

    assign ready_o  = !busy_q;
    assign digest_o = chain;

endmodule

// File: rtl/hmac_multiblock_core.sv
// rtl/hmac_multiblock_core.sv - multi-block HMAC-SHA-384/512 sequencer over inner/outer SHA engines
module hmac_multiblock_core
    import hmac_multiblock_pkg::*;
#(
    parameter logic [383:0] LFSR_INIT_SEED = 384'hc48555929cd58779f4819c1e6570c2ef20bccd503284e2d366f3273a66e9719b07ac999c80740d6277af88ceb4c3029c,
    parameter bit           HMAC512_EN     = 1'b1
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          zeroize_i,
    input  logic          init_cmd_i,
    input  logic          next_cmd_i,
    input  logic          last_i,
    input  logic          mode_i,
    input  logic [383:0]  lfsr_seed_i,
    input  logic [511:0]  key_i,
    input  logic [1023:0] block_msg_i,
    output logic          ready_o,
    output logic          tag_valid_o,
    output logic [511:0]  tag_o
);

    state_e        state_q, state_d, prev_q;
    logic [511:0]  key_q;
    logic [1023:0] block_q;
    logic          last_q, mode_q, first_q;
    logic          ready_q, tag_valid_q;
    logic [511:0]  tag_q;

    logic          clr;
    logic          entry;
    logic          accept_init, accept_next;
    logic          h1_init, h1_next, h2_init, h2_next;
    logic          h1_ready, h2_ready;
    logic [511:0]  h1_digest, h2_digest;
    logic [1023:0] h1_block, h2_block, final_block;
    logic [1023:0] key_block;
    logic [1:0]    sha_mode;
    logic [383:0]  entropy;

    assign clr   = reset_i | zeroize_i;
    assign entry = (state_q != prev_q);

    assign accept_init = init_cmd_i && (state_q == ST_IDLE || state_q == ST_WAIT_MSG);
    assign accept_next = next_cmd_i && !init_cmd_i && (state_q == ST_WAIT_MSG);

    // Engine commands are one-cycle pulses on the first cycle of each state.
    assign h1_init = entry && (state_q == ST_IPAD);
    assign h1_next = entry && (state_q == ST_MSG);
    assign h2_init = h1_next && first_q;
    assign h2_next = entry && (state_q == ST_HMAC);

    assign key_block = {key_q, 512'h0};
    assign sha_mode  = mode_q ? SHA_MODE_512 : SHA_MODE_384;
    assign h1_block  = h1_init ? (key_block ^ IPAD) : block_q;
    assign h2_block  = h2_init ? (key_block ^ OPAD) : final_block;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (accept_init) state_d = ST_IPAD;
            ST_IPAD:     if (!entry && h1_ready) state_d = ST_MSG;
            ST_MSG:      if (!entry && h1_ready && (h2_ready || !first_q))
                             state_d = last_q ? ST_HMAC : ST_WAIT_MSG;
            ST_WAIT_MSG: if (accept_init) state_d = ST_IPAD;
                         else if (accept_next) state_d = ST_MSG;
            ST_HMAC:     if (!entry && h2_ready) state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (clr) begin
            state_q     <= ST_IDLE;
            prev_q      <= ST_IDLE;
            key_q       <= '0;
            block_q     <= '0;
            last_q      <= 1'b0;
            mode_q      <= 1'b0;
            first_q     <= 1'b0;
            ready_q     <= 1'b1;
            tag_valid_q <= 1'b0;
            tag_q       <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= state_q;
            ready_q <= (state_d == ST_IDLE) || (state_d == ST_WAIT_MSG);
            if (accept_init) begin
                key_q       <= key_i;
                block_q     <= block_msg_i;
                last_q      <= last_i;
                mode_q      <= HMAC512_EN & mode_i;
                first_q     <= 1'b1;
                tag_valid_q <= 1'b0;
            end else if (accept_next) begin
                block_q <= block_msg_i;
                last_q  <= last_i;
            end
            if (state_q == ST_MSG && state_d != ST_MSG) begin
                first_q <= 1'b0;
            end
            if (state_q == ST_DONE) begin
                tag_q       <= mode_q ? h2_digest : {h2_digest[511:128], 128'h0};
                tag_valid_q <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < 12; i++) begin : g_lfsr
        hmac_lfsr #(.INIT(LFSR_INIT_SEED[32*i +: 32])) u_lfsr (
            .clk_i   (clk_i),
            .reset_i (clr),
            .load_i  (accept_init),
            .seed_i  (lfsr_seed_i[32*i +: 32]),
            .value_o (entropy[32*i +: 32])
        );
    end

    sha512_masked_core u_h1 (
        .clk_i     (clk_i),
        .reset_ni  (1'b1),
        .zeroize_i (clr),
        .init_i    (h1_init),
        .next_i    (h1_next),
        .mode_i    (sha_mode),
        .block_i   (h1_block),
        .entropy_i (entropy[383:192]),
        .ready_o   (h1_ready),
        .digest_o  (h1_digest)
    );

    sha512_masked_core u_h2 (
        .clk_i     (clk_i),
        .reset_ni  (1'b1),
        .zeroize_i (clr),
        .init_i    (h2_init),
        .next_i    (h2_next),
        .mode_i    (sha_mode),
        .block_i   (h2_block),
        .entropy_i (entropy[191:0]),
        .ready_o   (h2_ready),
        .digest_o  (h2_digest)
    );

    hmac_final_block_mux u_final_mux (
        .digest_i   (h1_digest),
        .mode_512_i (mode_q),
        .block_o    (final_block)
    );

    assign ready_o     = ready_q;
    assign tag_valid_o = tag_valid_q;
    assign tag_o       = tag_q;

endmodule
